// File: rtl/axi4_lite_pkg.sv
`default_nettype none
// ============================================================================
// axi4_lite_pkg : shared response codes, FSM state types and address decode
// Rev 1.0
// ============================================================================
package axi4_lite_pkg;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [0:0] {
        WR_IDLE = 1'b0,
        WR_RESP = 1'b1
    } wr_state_t;

    typedef enum logic [0:0] {
        RD_IDLE = 1'b0,
        RD_DATA = 1'b1
    } rd_state_t;

    // Byte address to word index; lsb is log2 of the data bus width in bytes.
    function automatic logic [31:0] addr_to_index(input logic [31:0] addr, input int unsigned lsb);
        return addr >> lsb;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi4_lite_slave_wr_ctrl.sv
`default_nettype none
// ============================================================================
// axi4_lite_slave_wr_ctrl : AW/W latching, write FSM and B channel; emits a
// one-cycle write strobe to the register bank. Macro: AXI4_LITE_REGFILE_SLVERR_EN
// Rev 1.0
// ============================================================================
module axi4_lite_slave_wr_ctrl #(
    parameter int DATA_BYTES = 4,
    parameter int ADDR_BYTES = 1,
    parameter int NUM_REGS   = 8
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        awvalid,
    output logic                        awready,
    input  logic [ADDR_BYTES*8-1:0]     awaddr,
    input  logic                        wvalid,
    output logic                        wready,
    input  logic [DATA_BYTES*8-1:0]     wdata,
    input  logic [DATA_BYTES-1:0]       wstrb,
    output logic                        bvalid,
    input  logic                        bready,
    output logic [1:0]                  bresp,
    output logic                        we_o,
    output logic [$clog2(NUM_REGS)-1:0] widx_o,
    output logic [DATA_BYTES*8-1:0]     wdata_o,
    output logic [DATA_BYTES-1:0]       wstrb_o
);
    import axi4_lite_pkg::*;

    localparam int DW       = DATA_BYTES * 8;
    localparam int AW       = ADDR_BYTES * 8;
    localparam int IDX_W    = $clog2(NUM_REGS);
    localparam int ADDR_LSB = $clog2(DATA_BYTES);

    wr_state_t             state_q;
    logic                  aw_held_q;
    logic                  w_held_q;
    logic                  awready_q;
    logic                  wready_q;
    logic                  bvalid_q;
    logic [1:0]            bresp_q;
    logic [AW-1:0]         addr_q;
    logic [DW-1:0]         data_q;
    logic [DATA_BYTES-1:0] strb_q;

    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_commit;
    logic                  w_in_range;
    logic [AW-1:0]         w_addr;
    logic [31:0]           w_word;
    logic                  w_unused;

    assign w_aw_hs  = awvalid && awready_q;
    assign w_w_hs   = wvalid && wready_q;
    // A channel counts as present when latched earlier or handshaking this edge.
    assign w_commit = (state_q == WR_IDLE) && (aw_held_q || w_aw_hs) && (w_held_q || w_w_hs);
    assign w_addr   = aw_held_q ? addr_q : awaddr;
    assign w_word   = addr_to_index(32'(w_addr), ADDR_LSB);

`ifdef AXI4_LITE_REGFILE_SLVERR_EN
    assign w_in_range = (w_word < 32'(NUM_REGS));
`else
    assign w_in_range = 1'b1;
`endif

    assign w_unused = ^w_word;

    assign we_o    = w_commit && w_in_range;
    assign widx_o  = w_word[IDX_W-1:0];
    assign wdata_o = w_held_q ? data_q : wdata;
    assign wstrb_o = w_held_q ? strb_q : wstrb;

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= WR_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
            addr_q    <= '0;
            data_q    <= '0;
            strb_q    <= '0;
        end else begin
            case (state_q)
                WR_IDLE: begin
                    if (w_commit) begin
                        state_q   <= WR_RESP;
                        aw_held_q <= 1'b0;
                        w_held_q  <= 1'b0;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                        bvalid_q  <= 1'b1;
                        bresp_q   <= w_in_range ? OKAY : SLVERR;
                    end else begin
                        if (w_aw_hs) begin
                            aw_held_q <= 1'b1;
                            addr_q    <= awaddr;
                            awready_q <= 1'b0;
                        end else if (!aw_held_q) begin
                            awready_q <= 1'b1;
                        end
                        if (w_w_hs) begin
                            w_held_q <= 1'b1;
                            data_q   <= wdata;
                            strb_q   <= wstrb;
                            wready_q <= 1'b0;
                        end else if (!w_held_q) begin
                            wready_q <= 1'b1;
                        end
                    end
                end
                WR_RESP: begin
                    if (bready) begin
                        state_q   <= WR_IDLE;
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                    end
                end
                default: state_q <= WR_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi4_lite_regfile.sv
`default_nettype none
// ============================================================================
// axi4_lite_regfile : AXI4-Lite slave register bank with parallel export.
// Macro: AXI4_LITE_REGFILE_SLVERR_EN (out-of-range index -> SLVERR). Rev 1.0
// ============================================================================
module axi4_lite_regfile #(
    parameter int DATA_BYTES = 4,
    parameter int ADDR_BYTES = 1,
    parameter int NUM_REGS   = 8
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic                             awvalid,
    output logic                             awready,
    input  logic [ADDR_BYTES*8-1:0]          awaddr,
    input  logic [2:0]                       awprot,
    input  logic                             wvalid,
    output logic                             wready,
    input  logic [DATA_BYTES*8-1:0]          wdata,
    input  logic [DATA_BYTES-1:0]            wstrb,
    output logic                             bvalid,
    input  logic                             bready,
    output logic [1:0]                       bresp,
    input  logic                             arvalid,
    output logic                             arready,
    input  logic [ADDR_BYTES*8-1:0]          araddr,
    input  logic [2:0]                       arprot,
    output logic                             rvalid,
    input  logic                             rready,
    output logic [DATA_BYTES*8-1:0]          rdata,
    output logic [1:0]                       rresp,
    output logic [NUM_REGS*DATA_BYTES*8-1:0] regs_o
);
    import axi4_lite_pkg::*;

    localparam int DW       = DATA_BYTES * 8;
    localparam int IDX_W    = $clog2(NUM_REGS);
    localparam int ADDR_LSB = $clog2(DATA_BYTES);

    logic                  w_we;
    logic [IDX_W-1:0]      w_widx;
    logic [DW-1:0]         w_wdata;
    logic [DATA_BYTES-1:0] w_wstrb;

    logic [DW-1:0]         regs_q [NUM_REGS];

    rd_state_t             rd_state_q;
    logic                  arready_q;
    logic                  rvalid_q;
    logic [DW-1:0]         rdata_q;
    logic [1:0]            rresp_q;

    logic [31:0]           w_rd_word;
    logic [IDX_W-1:0]      w_rd_idx;
    logic                  w_rd_in_range;
    logic                  w_unused;

    axi4_lite_slave_wr_ctrl #(
        .DATA_BYTES (DATA_BYTES),
        .ADDR_BYTES (ADDR_BYTES),
        .NUM_REGS   (NUM_REGS)
    ) u_wr_ctrl (
        .aclk    (aclk),
        .aresetn (aresetn),
        .awvalid (awvalid),
        .awready (awready),
        .awaddr  (awaddr),
        .wvalid  (wvalid),
        .wready  (wready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .bvalid  (bvalid),
        .bready  (bready),
        .bresp   (bresp),
        .we_o    (w_we),
        .widx_o  (w_widx),
        .wdata_o (w_wdata),
        .wstrb_o (w_wstrb)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (w_we) begin
            for (int b = 0; b < DATA_BYTES; b++) begin
                if (w_wstrb[b]) begin
                    regs_q[w_widx][b*8 +: 8] <= w_wdata[b*8 +: 8];
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_export
        assign regs_o[i*DW +: DW] = regs_q[i];
    end

    assign w_rd_word = addr_to_index(32'(araddr), ADDR_LSB);
    assign w_rd_idx  = w_rd_word[IDX_W-1:0];

`ifdef AXI4_LITE_REGFILE_SLVERR_EN
    assign w_rd_in_range = (w_rd_word < 32'(NUM_REGS));
`else
    assign w_rd_in_range = 1'b1;
`endif

    assign w_unused = ^{awprot, arprot, w_rd_word};

    // Reads sample regs_q before any same-edge write lands, so they see the old value.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_state_q <= RD_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= OKAY;
        end else begin
            case (rd_state_q)
                RD_IDLE: begin
                    if (!arready_q) begin
                        arready_q <= 1'b1;
                    end else if (arvalid) begin
                        rd_state_q <= RD_DATA;
                        arready_q  <= 1'b0;
                        rvalid_q   <= 1'b1;
                        rdata_q    <= w_rd_in_range ? regs_q[w_rd_idx] : '0;
                        rresp_q    <= w_rd_in_range ? OKAY : SLVERR;
                    end
                end
                RD_DATA: begin
                    if (rready) begin
                        rd_state_q <= RD_IDLE;
                        rvalid_q   <= 1'b0;
                        arready_q  <= 1'b1;
                    end
                end
                default: rd_state_q <= RD_IDLE;
            endcase
        end
    end

    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_regfile.sv
`default_nettype none
// ============================================================================
// tb_axi4_lite_regfile : scoreboard bench for the AXI4-Lite register file
// Rev 1.0
// ============================================================================
module tb_axi4_lite_regfile;

    logic         aclk;
    logic         aresetn;
    logic         awvalid, awready, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rvalid, rready;
    logic [7:0]   awaddr, araddr;
    logic [2:0]   awprot, arprot;
    logic [31:0]  wdata, rdata;
    logic [3:0]   wstrb;
    logic [1:0]   bresp, rresp;
    logic [255:0] regs_o;

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [31:0]  model [8];
    logic [1:0]   b_q [$];
    logic [33:0]  r_q [$];

    axi4_lite_regfile #(
        .DATA_BYTES (4),
        .ADDR_BYTES (1),
        .NUM_REGS   (8)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .awvalid (awvalid),
        .awready (awready),
        .awaddr  (awaddr),
        .awprot  (awprot),
        .wvalid  (wvalid),
        .wready  (wready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .bvalid  (bvalid),
        .bready  (bready),
        .bresp   (bresp),
        .arvalid (arvalid),
        .arready (arready),
        .araddr  (araddr),
        .arprot  (arprot),
        .rvalid  (rvalid),
        .rready  (rready),
        .rdata   (rdata),
        .rresp   (rresp),
        .regs_o  (regs_o)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [2:0] exp_idx(input logic [7:0] a);
        return a[4:2];
    endfunction

    function automatic logic exp_ok(input logic [7:0] a);
`ifdef AXI4_LITE_REGFILE_SLVERR_EN
        return a < 8'd32;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [255:0] exp_regs();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = model[i];
        return v;
    endfunction

    task automatic push_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        if (exp_ok(a)) begin
            for (int b = 0; b < 4; b++) if (s[b]) model[exp_idx(a)][b*8 +: 8] = d[b*8 +: 8];
            b_q.push_back(2'b00);
        end else begin
            b_q.push_back(2'b10);
        end
    endtask

    task automatic push_read(input logic [7:0] a);
        if (exp_ok(a)) r_q.push_back({2'b00, model[exp_idx(a)]});
        else           r_q.push_back({2'b10, 32'h0});
    endtask

    // Returns on the falling edge after the final AW/W handshake.
    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        logic aw_fire, w_fire;
        int   n;
        n = 0;
        push_write(a, d, s);
        @(negedge aclk);
        awvalid = 1'b1; awaddr = a; wvalid = 1'b1; wdata = d; wstrb = s;
        while ((awvalid || wvalid) && n < 20) begin
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            @(negedge aclk);
            if (aw_fire) awvalid = 1'b0;
            if (w_fire)  wvalid  = 1'b0;
            n++;
        end
        if (awvalid || wvalid) begin
            n_tests++; n_fail++;
            $display("FAIL write_timeout: addr %h not accepted after %0d cycles", a, n);
            awvalid = 1'b0; wvalid = 1'b0;
        end
    endtask

    task automatic do_read(input logic [7:0] a);
        logic fire;
        int   n;
        n = 0;
        fire = 1'b0;
        push_read(a);
        @(negedge aclk);
        arvalid = 1'b1; araddr = a;
        while (!fire && n < 20) begin
            fire = arready;
            @(negedge aclk);
            n++;
        end
        arvalid = 1'b0;
        if (!fire) begin
            n_tests++; n_fail++;
            $display("FAIL read_timeout: addr %h not accepted after %0d cycles", a, n);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge aclk);
        n_tests++;
        if ({awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp, regs_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got aw%b w%b b%b ar%b r%b regs %h required all zero",
                     awready, wready, bvalid, arready, rvalid, regs_o);
        end
        aresetn = 1'b1;
        #1;
        n_tests++;
        if ({awready, wready, arready} !== 3'b000) begin
            n_fail++;
            $display("FAIL ready_before_edge: got %b required 000", {awready, wready, arready});
        end
        @(negedge aclk);
        n_tests++;
        if ({awready, wready, arready} !== 3'b111) begin
            n_fail++;
            $display("FAIL ready_after_release: got %b required 111", {awready, wready, arready});
        end
    endtask

    task automatic test_write_basic();
        logic [1:0] e;
        do_write(8'h04, 32'hDEADBEEF, 4'hF);
        e = b_q.pop_front();
        n_tests++;
        if ({bvalid, bresp} !== {1'b1, e}) begin
            n_fail++;
            $display("FAIL write_basic_b: got bvalid %b bresp %b required 1 %b", bvalid, bresp, e);
        end
        n_tests++;
        if (regs_o[63:32] !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL write_basic_reg: got %h required deadbeef", regs_o[63:32]);
        end
        @(negedge aclk);
        n_tests++;
        if ({bvalid, awready, wready} !== 3'b011) begin
            n_fail++;
            $display("FAIL write_basic_release: got %b required 011", {bvalid, awready, wready});
        end
    endtask

    task automatic test_w_before_aw();
        logic [1:0] e;
        push_write(8'h08, 32'h12345678, 4'hF);
        @(negedge aclk);
        wvalid = 1'b1; wdata = 32'h12345678; wstrb = 4'hF;
        @(negedge aclk);
        wvalid = 1'b0;
        n_tests++;
        if ({wready, awready} !== 2'b01) begin
            n_fail++;
            $display("FAIL w_first_ready: got wready %b awready %b required 0 1", wready, awready);
        end
        @(negedge aclk);
        n_tests++;
        if ({bvalid, regs_o[95:64]} !== {1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL w_first_early: got bvalid %b reg2 %h required 0 00000000", bvalid, regs_o[95:64]);
        end
        awvalid = 1'b1; awaddr = 8'h08;
        @(negedge aclk);
        awvalid = 1'b0;
        e = b_q.pop_front();
        n_tests++;
        if ({bvalid, bresp, regs_o[95:64]} !== {1'b1, e, model[2]}) begin
            n_fail++;
            $display("FAIL w_first_commit: got bvalid %b bresp %b reg2 %h required 1 %b %h",
                     bvalid, bresp, regs_o[95:64], e, model[2]);
        end
        @(negedge aclk);
    endtask

    task automatic test_strobe();
        logic [1:0] e;
        do_write(8'h04, 32'h000000AA, 4'b0001);
        e = b_q.pop_front();
        n_tests++;
        if ({bvalid, bresp} !== {1'b1, e}) begin
            n_fail++;
            $display("FAIL strobe_b: got bvalid %b bresp %b required 1 %b", bvalid, bresp, e);
        end
        n_tests++;
        if (regs_o[63:32] !== 32'hDEADBEAA) begin
            n_fail++;
            $display("FAIL strobe_reg: got %h required deadbeaa", regs_o[63:32]);
        end
        @(negedge aclk);
    endtask

    task automatic test_read_backpressure();
        logic [33:0] e;
        rready = 1'b0;
        do_read(8'h04);
        e = r_q.pop_front();
        n_tests++;
        if ({rvalid, rresp, rdata} !== {1'b1, e}) begin
            n_fail++;
            $display("FAIL read_bp_first: got rvalid %b rresp %b rdata %h required 1 %b %h",
                     rvalid, rresp, rdata, e[33:32], e[31:0]);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge aclk);
            n_tests++;
            if ({rvalid, arready, rresp, rdata} !== {2'b10, e}) begin
                n_fail++;
                $display("FAIL read_bp_hold%0d: got rvalid %b arready %b rdata %h required 1 0 %h",
                         c, rvalid, arready, rdata, e[31:0]);
            end
        end
        rready = 1'b1;
        @(negedge aclk);
        n_tests++;
        if ({rvalid, arready} !== 2'b01) begin
            n_fail++;
            $display("FAIL read_bp_release: got %b required 01", {rvalid, arready});
        end
    endtask

    task automatic test_out_of_range();
        logic [1:0]  e;
        logic [33:0] er;
        do_write(8'hC4, 32'h55AA55AA, 4'hF);
        e = b_q.pop_front();
        n_tests++;
        if ({bvalid, bresp} !== {1'b1, e}) begin
            n_fail++;
            $display("FAIL oor_bresp: got bvalid %b bresp %b required 1 %b", bvalid, bresp, e);
        end
        n_tests++;
        if (regs_o !== exp_regs()) begin
            n_fail++;
            $display("FAIL oor_regs: got %h required %h", regs_o, exp_regs());
        end
        @(negedge aclk);
        do_read(8'hC4);
        er = r_q.pop_front();
        n_tests++;
        if ({rvalid, rresp, rdata} !== {1'b1, er}) begin
            n_fail++;
            $display("FAIL oor_read: got rvalid %b rresp %b rdata %h required 1 %b %h",
                     rvalid, rresp, rdata, er[33:32], er[31:0]);
        end
        @(negedge aclk);
    endtask

    task automatic test_concurrent_rw();
        logic [31:0] d;
        logic [1:0]  e;
        logic [33:0] er;
        d = $urandom;
        push_read(8'h04);
        push_write(8'h04, d, 4'hF);
        @(negedge aclk);
        awvalid = 1'b1; awaddr = 8'h04; wvalid = 1'b1; wdata = d; wstrb = 4'hF;
        arvalid = 1'b1; araddr = 8'h04;
        @(negedge aclk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        e  = b_q.pop_front();
        er = r_q.pop_front();
        n_tests++;
        if ({bvalid, bresp} !== {1'b1, e}) begin
            n_fail++;
            $display("FAIL concurrent_b: got bvalid %b bresp %b required 1 %b", bvalid, bresp, e);
        end
        n_tests++;
        if ({rvalid, rresp, rdata} !== {1'b1, er}) begin
            n_fail++;
            $display("FAIL concurrent_r: got rvalid %b rdata %h required 1 %h (pre-write)",
                     rvalid, rdata, er[31:0]);
        end
        n_tests++;
        if (regs_o[63:32] !== d) begin
            n_fail++;
            $display("FAIL concurrent_reg: got %h required %h", regs_o[63:32], d);
        end
        @(negedge aclk);
    endtask

    task automatic test_back_to_back();
        logic        fire;
        logic [1:0]  e;
        logic [31:0] d;
        logic [3:0]  s;
        int          k, cyc;
        k = 0; cyc = 0;
        d = $urandom; s = 4'($urandom_range(0, 15));
        push_write(8'h10, d, s);
        @(negedge aclk);
        awvalid = 1'b1; awaddr = 8'h10; wvalid = 1'b1; wdata = d; wstrb = s;
        while (k < 4 && cyc < 40) begin
            fire = awready && wready;
            @(negedge aclk);
            cyc++;
            if (bvalid) begin
                n_tests++;
                if (b_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_spurious_b: got bvalid 1 required no response pending");
                end else begin
                    e = b_q.pop_front();
                    if (bresp !== e) begin
                        n_fail++;
                        $display("FAIL b2b_bresp: got %b required %b", bresp, e);
                    end
                end
            end
            if (fire) begin
                k++;
                if (k < 4) begin
                    d = $urandom; s = 4'($urandom_range(0, 15));
                    awaddr = 8'(8'h10 + k * 4);
                    push_write(awaddr, d, s);
                    wdata = d; wstrb = s;
                end else begin
                    awvalid = 1'b0; wvalid = 1'b0;
                end
            end
        end
        awvalid = 1'b0; wvalid = 1'b0;
        n_tests++;
        if (cyc !== 7 || b_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_throughput: got %0d cycles, %0d unanswered required 7 cycles, 0 unanswered",
                     cyc, b_q.size());
        end
        n_tests++;
        if (regs_o !== exp_regs()) begin
            n_fail++;
            $display("FAIL b2b_regs: got %h required %h", regs_o, exp_regs());
        end
        @(negedge aclk);
    endtask

    task automatic test_reset_mid();
        logic [1:0] e;
        bready = 1'b0;
        do_write(8'h0C, 32'hCAFEF00D, 4'hF);
        n_tests++;
        if (bvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_pending: got bvalid %b required 1", bvalid);
        end
        aresetn = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) model[i] = 32'h0;
        b_q.delete();
        n_tests++;
        if ({bvalid, awready, wready, arready, rvalid, regs_o} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_clear: got bvalid %b rdy %b regs %h required all zero",
                     bvalid, {awready, wready, arready}, regs_o);
        end
        bready = 1'b1;
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        n_tests++;
        if ({bvalid, awready, wready, arready} !== 4'b0111) begin
            n_fail++;
            $display("FAIL rst_mid_recover: got %b required 0111", {bvalid, awready, wready, arready});
        end
        do_write(8'h00, 32'hA5A5_0001, 4'hF);
        e = b_q.pop_front();
        n_tests++;
        if ({bvalid, bresp, regs_o} !== {1'b1, e, exp_regs()}) begin
            n_fail++;
            $display("FAIL rst_mid_after_write: got bvalid %b bresp %b reg0 %h required 1 %b %h",
                     bvalid, bresp, regs_o[31:0], e, model[0]);
        end
        @(negedge aclk);
    endtask

    initial begin
        aresetn = 1'b0;
        awvalid = 1'b0; awaddr = '0; awprot = '0;
        wvalid  = 1'b0; wdata  = '0; wstrb  = '0;
        bready  = 1'b1;
        arvalid = 1'b0; araddr = '0; arprot = '0;
        rready  = 1'b1;
        for (int i = 0; i < 8; i++) model[i] = 32'h0;

        test_reset();
        test_write_basic();
        test_w_before_aw();
        test_strobe();
        test_read_backpressure();
        test_out_of_range();
        test_concurrent_rw();
        test_back_to_back();
        test_reset_mid();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi4_lite_regfile.md
# axi4_lite_regfile

Synthesizable AXI4-Lite slave register file: the responder end of the AXI4-Lite interface driven by the team's master BFM. It accepts single-beat writes and reads on the five AXI4-Lite channels and stores data in a bank of `NUM_REGS` registers, which are exported in parallel to the surrounding logic. It is the first RTL target for the existing master BFM benches and the standard control/status block for later designs.

## Interface
- `DATA_BYTES`, 4: data bus width in bytes.
- `ADDR_BYTES`, 1: address bus width in bytes.
- `NUM_REGS`, 8: number of registers. Must be a power of two, ≥2.
- `aclk` in 1: sole clock; all logic is rising-edge.
- `aresetn` in 1: asynchronous, active-low reset.
- `awvalid` in 1 / `awready` out 1 / `awaddr` in `ADDR_BYTES*8` / `awprot` in 3 (ignored).
- `wvalid` in 1 / `wready` out 1 / `wdata` in `DATA_BYTES*8` / `wstrb` in `DATA_BYTES`.
- `bvalid` out 1 / `bready` in 1 / `bresp` out 2.
- `arvalid` in 1 / `arready` out 1 / `araddr` in `ADDR_BYTES*8` / `arprot` in 3 (ignored).
- `rvalid` out 1 / `rready` in 1 / `rdata` out `DATA_BYTES*8` / `rresp` out 2.
- `regs_o` out `NUM_REGS*DATA_BYTES*8`: current register contents. Register i occupies bits `[i*DATA_BYTES*8 +: DATA_BYTES*8]`.

## Operation
- Every output is registered. While `aresetn` is low, all outputs are 0 and all registers are 0. The three ready signals rise on the first edge after reset deasserts.
- **Address decode:**
  - Word index = `addr >> log2(DATA_BYTES)`.
  - The low `log2(DATA_BYTES)` address bits are ignored.
- **Write FSM (`WR_IDLE`, `WR_RESP`):**
  - In `WR_IDLE`, AW and W are accepted independently:
    - `awready` is high until an address is held.
    - `wready` is high until data is held.
    - Whichever channel arrives first is latched, and its ready drops.
  - On the edge where both address and data are available (latched or handshaking that same edge):
    - Commit the write with byte enables: byte b is updated iff `wstrb[b]`.
    - Load `bresp`, set `bvalid`, go to `WR_RESP`.
  - In `WR_RESP`, `awready` and `wready` are low. On `bvalid && bready`, clear `bvalid`, raise both readies, and return to `WR_IDLE`.
  - `wstrb` = 0 is a legal no-op write and returns OKAY.
- **Read FSM (`RD_IDLE`, `RD_DATA`):**
  - In `RD_IDLE`, `arready` = 1. On the AR handshake:
    - Register `rdata`/`rresp` from the current register values.
    - Drop `arready`, set `rvalid`, go to `RD_DATA`.
  - In `RD_DATA`, `rdata` and `rresp` stay stable until `rvalid && rready`. The block then returns to `RD_IDLE`.
- **Concurrency:**
  - The read and write FSMs are fully independent.
  - A read handshake on the same edge as a write commit to the same register returns the pre-write value.
- **Reset mid-transaction:** both FSMs return to idle and `bvalid`/`rvalid` drop immediately. The pending transaction is discarded with no response.

## Timing
- Write response: `bvalid` high one cycle after the edge on which the last of AW/W is accepted.
- Write effect: `regs_o` reflects the write in the same cycle that `bvalid` rises.
- Read response: `rvalid` high one cycle after the AR handshake.
- Peak throughput: one write per 2 cycles and one read per 2 cycles, concurrently, with `bready`/`rready` held high.
- Backpressure holds the FSM in its response state indefinitely. There is no timeout.

## Configuration
- `AXI4_LITE_REGFILE_SLVERR_EN`:
  - **Defined:** an index ≥ `NUM_REGS` returns `SLVERR` (2'b10). Writes do not modify any register; reads return `rdata` = 0.
  - **Undefined:** the index wraps to `index mod NUM_REGS` (low `log2(NUM_REGS)` bits), and every access returns OKAY.

## Structure
- Package `axi4_lite_pkg` holds:
  - Response constants OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - Typedefs `wr_state_t` and `rd_state_t`.
  - The address-to-index function.
- One sub-module: `axi4_lite_slave_wr_ctrl`. It contains the AW/W latching, the write FSM and the B channel, and outputs a one-cycle write-enable, index and strobe to the register bank.
- The read path and register bank live in the top module.

## Test plan
- Write 0xDEADBEEF to 0x04 with `wstrb`=4'hF, AW and W together, `bready`=1. Expected: `bvalid` one cycle later with `bresp`=00, and `regs_o[63:32]`=0xDEADBEEF.
- W two cycles before AW (0x08, 0x12345678). Expected: `wready` drops after the W handshake, `awready` stays high, write commits on the AW edge, and register 2 = 0x12345678.
- Register 1 = 0xDEADBEEF, then write 0x000000AA with `wstrb`=4'b0001. Expected: register 1 = 0xDEADBEAA.
- Read 0x04 with `rready` held low for 5 cycles. Expected: `rvalid` held, `rdata`=0xDEADBEAA stable, `arready` low throughout, and release after `rready` rises.
- Access 0xC4 (index 49):
  - With the macro: write gets `bresp`=10 and no register changes; read gets `rresp`=10 and `rdata`=0.
  - Without the macro: the access hits register 1 with OKAY.
- Assert `aresetn` low while `bvalid` is pending. Expected: `bvalid`=0 immediately, all `regs_o`=0, and readies high on the first edge after release.
